// File: rtl/rx32_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package rx32_mem_pkg;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory with one-cycle read latency.
// Data port has priority; a saturating starvation counter forces an instruction slot.
//
// state  | meaning
// ARB    | both ports arbitrated; data wins unless instruction is starved
// LOCKED | data port owns memory for an atomic sequence; instruction blocked
module mem_arbiter
  import rx32_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_lock,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state, state_nxt;
  owner_t        owner, owner_nxt;
  logic          resp_we, resp_we_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      owner      <= OWN_NONE;
      resp_we    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      resp_we    <= resp_we_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    state_nxt   = state;
    owner_nxt   = OWN_NONE;
    resp_we_nxt = 1'b0;
    starve_nxt  = '0;

    // Grants are forced low while reset is held so no outputs toggle.
    if (!reset) begin
      unique case (state)
        ARB: begin
          if (d_req && !(i_req && starve_cnt == LIMIT)) d_gnt = 1'b1;
          else if (i_req)                                i_gnt = 1'b1;
          if (d_gnt && d_lock) state_nxt = LOCKED;
        end
        LOCKED: begin
          d_gnt = d_req;
          if (!d_lock) state_nxt = ARB;
        end
        default: state_nxt = ARB;
      endcase
    end

    if (i_gnt) begin
      owner_nxt = OWN_I;
    end else if (d_gnt) begin
      owner_nxt   = OWN_D;
      resp_we_nxt = d_we;
    end

    if (i_req && !i_gnt)
      starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
  end

  always_comb begin
    m_en    = i_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : 32'h0);
    m_wdata = d_gnt ? d_wdata : 32'h0;
  end

  // Response gating on reset suppresses a response whose grant preceded reset.
  assign i_rvalid = !reset && (owner == OWN_I);
  assign d_rvalid = !reset && (owner == OWN_D);
  assign i_rdata  = i_rvalid ? m_rdata : 32'h0;
  assign d_rdata  = (d_rvalid && !resp_we) ? m_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, d_lock;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[9:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_we = 0; d_lock = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[8'h04] = 32'h0050_0093;
    idle_inputs();
    reset = 1;

    // Reset holds all outputs low even with both requests present.
    repeat (2) cyc();
    i_req = 1; d_req = 1; i_addr = 32'h10; d_addr = 32'h20;
    #3;
    check("rst_i_gnt", i_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_m_en", m_en, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    cyc();
    reset = 0;
    idle_inputs();
    #3;
    check("idle_m_en", m_en, 0);
    check("idle_rvalid", {i_rvalid, d_rvalid}, 0);

    // Instruction fetch alone.
    cyc();
    i_req = 1; i_addr = 32'h10;
    #3;
    check("if_i_gnt", i_gnt, 1);
    check("if_d_gnt", d_gnt, 0);
    check("if_m_addr", m_addr, 32'h10);
    check("if_m_we", m_we, 0);
    cyc();
    idle_inputs();
    #3;
    check("if_i_rvalid", i_rvalid, 1);
    check("if_i_rdata", i_rdata, 32'h0050_0093);
    check("if_d_rvalid", d_rvalid, 0);
    cyc();
    #3;
    check("if_i_rvalid_once", i_rvalid, 0);
    check("if_i_rdata_zero", i_rdata, 0);

    // Data write then read-back, back to back.
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    #3;
    check("wr_d_gnt", d_gnt, 1);
    check("wr_m_we", m_we, 1);
    check("wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("wr_m_addr", m_addr, 32'h40);
    cyc();
    d_we = 0; d_wdata = 0;
    #3;
    check("wr_d_rvalid", d_rvalid, 1);
    check("wr_d_rdata", d_rdata, 0);
    check("rd_d_gnt", d_gnt, 1);
    check("rd_m_we", m_we, 0);
    cyc();
    idle_inputs();
    #3;
    check("rd_d_rvalid", d_rvalid, 1);
    check("rd_d_rdata", d_rdata, 32'hDEAD_BEEF);
    check("rd_i_rvalid", i_rvalid, 0);

    // Starvation: data wins 4 cycles, instruction gets the 5th, repeat.
    cyc();
    i_req = 1; d_req = 1; i_addr = 32'h10; d_addr = 32'h44;
    for (int k = 0; k < 10; k++) begin
      #3;
      check($sformatf("stv_i_gnt_%0d", k), i_gnt, (k % 5 == 4) ? 1 : 0);
      check($sformatf("stv_d_gnt_%0d", k), d_gnt, (k % 5 == 4) ? 0 : 1);
      if (k > 0) check($sformatf("stv_i_rvalid_%0d", k), i_rvalid, (k % 5 == 0) ? 1 : 0);
      cyc();
    end
    idle_inputs();
    cyc();

    // Lock: data holds ownership 6 cycles while instruction waits.
    i_req = 1; i_addr = 32'h10; d_req = 1; d_lock = 1; d_addr = 32'h48;
    for (int k = 0; k < 6; k++) begin
      #3;
      check($sformatf("lck_d_gnt_%0d", k), d_gnt, 1);
      check($sformatf("lck_i_gnt_%0d", k), i_gnt, 0);
      cyc();
    end
    d_lock = 0; d_req = 0;
    #3;
    check("lck_drop_i_gnt", i_gnt, 0);
    cyc();
    d_req = 1;
    #3;
    check("lck_after_i_gnt", i_gnt, 1);
    check("lck_after_d_gnt", d_gnt, 0);
    cyc();
    idle_inputs();
    cyc();

    // Reset mid-transaction while locked.
    d_req = 1; d_lock = 1; d_addr = 32'h40;
    #3;
    check("mrst_d_gnt", d_gnt, 1);
    cyc();
    reset = 1;
    #3;
    check("mrst_d_rvalid", d_rvalid, 0);
    check("mrst_d_rdata", d_rdata, 0);
    check("mrst_d_gnt_low", d_gnt, 0);
    check("mrst_m_en", m_en, 0);
    cyc();
    reset = 0;
    idle_inputs();
    #3;
    check("mrst_post_rvalid", {i_rvalid, d_rvalid}, 0);
    cyc();
    #3;
    check("mrst_post_rvalid2", {i_rvalid, d_rvalid}, 0);
    i_req = 1; i_addr = 32'h10;
    #1;
    check("mrst_arb_i_gnt", i_gnt, 1);
    cyc();
    idle_inputs();
    #3;
    check("mrst_arb_i_rvalid", i_rvalid, 1);

    // Random traffic: mutual exclusion and one response per grant.
    begin
      logic prev_i, prev_d;
      prev_i = 0; prev_d = 0;
      for (int k = 0; k < 200; k++) begin
        cyc();
        i_req   = 1'($urandom_range(0, 1));
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_lock  = ($urandom_range(0, 3) == 0);
        i_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        d_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        d_wdata = $urandom;
        #3;
        check("rnd_excl", {31'h0, i_gnt & d_gnt}, 0);
        check("rnd_i_rvalid", i_rvalid, prev_i);
        check("rnd_d_rvalid", d_rvalid, prev_d);
        prev_i = i_gnt;
        prev_d = d_gnt;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameter STARVE_LIMIT, default 4, meaning the maximum consecutive cycles an instruction request may be denied.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high; the ports are named clk and reset.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 i_req  input  1  instruction-fetch read request.
REQ-006 i_addr  input  32  instruction fetch byte address.
REQ-007 i_gnt  output  1  instruction request accepted this cycle.
REQ-008 i_rvalid  output  1  instruction read data valid.
REQ-009 i_rdata  output  32  instruction read data.
REQ-010 d_req  input  1  data-port request.
REQ-011 d_we  input  1  data request is a write.
REQ-012 d_lock  input  1  hold data ownership (atomic sequence).
REQ-013 d_addr  input  32  data byte address.
REQ-014 d_wdata  input  32  data write value.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  data response (read data or write acknowledge).
REQ-017 d_rdata  output  32  data read value.
REQ-018 m_en, m_we  output  1 each  shared single-port memory enable and write strobe.
REQ-019 m_addr, m_wdata  output  32 each  memory address and write data.
REQ-020 m_rdata  input  32  memory read data, valid one cycle after m_en.

Function
REQ-021 At most one of i_gnt and d_gnt SHALL be high in any cycle; grants are combinational from the current requests and state.
REQ-022 The granted requester's addr, we and wdata SHALL drive m_addr, m_we and m_wdata with m_en=1 in the grant cycle; with no grant, m_en=0, m_we=0, m_addr=0 and m_wdata=0.
REQ-023 The instruction port SHALL always drive m_we=0 and m_wdata=0.
REQ-024 FSM states SHALL be ARB and LOCKED.
REQ-025 In ARB, when only one request is high, that request SHALL be granted.
REQ-026 In ARB, when both requests are high, data SHALL win unless starve_cnt==STARVE_LIMIT, in which case instruction wins.
REQ-027 starve_cnt SHALL increment when i_req && !i_gnt, saturate at STARVE_LIMIT, and clear when i_gnt or !i_req.
REQ-028 ARB SHALL move to LOCKED at the clock edge where d_gnt && d_lock.
REQ-029 In LOCKED, only the data port SHALL be granted, regardless of starve_cnt.
REQ-030 LOCKED SHALL return to ARB at the first edge with d_lock==0, whether or not d_req is high.
REQ-031 The requester granted in cycle N SHALL see its rvalid high for exactly one cycle in N+1, with the other rvalid low.
REQ-032 Read responses SHALL return m_rdata on rdata; write acknowledges SHALL assert d_rvalid with d_rdata=0.
REQ-033 i_rdata and d_rdata SHALL be 0 whenever their rvalid is low.
REQ-034 Back-to-back grants SHALL be accepted every cycle (throughput 1 per cycle, latency 1).

Reset
REQ-035 On reset, the state SHALL be ARB, starve_cnt 0, and the response-owner register cleared.
REQ-036 During reset, all outputs SHALL be 0.
REQ-037 A reset asserted in the cycle after a grant SHALL suppress that grant's rvalid; no response SHALL appear after reset deasserts.

Structure
REQ-038 Package rx32_mem_pkg SHALL hold the state enum {ARB, LOCKED}, the owner enum {OWN_NONE, OWN_I, OWN_D}, and the STARVE_LIMIT default constant.
REQ-039 The block SHALL be a single module with no sub-modules; the grant mux, FSM, starvation counter and response-owner register are inline.

Verification
REQ-040 Single-requester cases: i_req=1, i_addr=0x10 with memory returning 0x00500093 -> i_gnt same cycle, m_addr=0x10; i_rvalid=1 and i_rdata=0x00500093 next cycle.
REQ-041 Write then read-back: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> m_we=1, next-cycle d_rvalid=1 with d_rdata=0; a following read of 0x40 -> d_rdata=0xDEADBEEF.
REQ-042 Starvation, STARVE_LIMIT=4: i_req and d_req held high -> d_gnt for 4 cycles, i_gnt in the 5th cycle, then the count restarts with data winning.
REQ-043 Lock: data granted with d_lock=1 for 6 cycles while i_req=1 -> no i_gnt during the lock; i_gnt on the first arbitrated cycle after d_lock drops, since starve_cnt is saturated.
REQ-044 Reset mid-transaction: d_gnt in cycle N, reset high in N+1 -> d_rvalid=0 in N+1 and all outputs 0; state ARB afterwards.
REQ-045 Randomized traffic check: never i_gnt && d_gnt; every grant is followed by exactly one rvalid to the same requester.
